jpc_fetch_ctrl: RTL and testbench
=================================

Name: jpc_fetch_ctrl

Overview:
Fetch sequencer that drives the program counter (jpc_pc) and the instruction-memory request port. It loads the boot PC, issues one fetch at a time, and presents fetched instructions to decode with a valid/ready handshake. It applies branch redirects and traps, and discards any response that is in flight when a redirect or trap occurs.

Parameters:
ADDR_W, `JPC_ADDRESS_WIDTH (32), address/PC width
RESET_PC, 32'h0000_0000, PC loaded after reset
TRAP_VEC, 32'h0000_0080, PC loaded on trap_I

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
pc_I  in  ADDR_W  current PC from jpc_pc
next_pc_O  out  ADDR_W  next PC to jpc_pc
pc_en_O  out  1  PC load enable to jpc_pc
imem_req_O  out  1  fetch request valid
imem_addr_O  out  ADDR_W  fetch address
imem_ack_I  in  1  request accepted; imem samples addr only in this cycle
imem_rvalid_I  in  1  response valid, 1 cycle, in order, one per accepted request
imem_rdata_I  in  32  instruction word
inst_valid_O  out  1  instruction valid to decode
inst_O  out  32  instruction
inst_pc_O  out  ADDR_W  PC of inst_O
inst_ready_I  in  1  decode accepts
redirect_I  in  1  branch/jump taken
redirect_pc_I  in  ADDR_W  redirect target
trap_I  in  1  trap request
state_O  out  3  debug: current state encoding

Behaviour:
- Reset (rst=0 at clk edge): state=BOOT; inst_O=0, inst_pc_O=0. All outputs are 0 while rst=0, including pc_en_O, imem_req_O and inst_valid_O.
- jpc_pc updates one cycle after pc_en_O, so pc_I reflects next_pc_O in the following cycle.
- State encodings: BOOT=0, REQ=1, WAIT=2, HOLD=3, DRAIN=4.
- BOOT: pc_en_O=1, next_pc_O=RESET_PC. Transition to REQ. Redirect and trap are ignored in BOOT.
- REQ: imem_req_O=1, imem_addr_O=pc_I (combinational). If imem_ack_I=1, go to WAIT; otherwise stay in REQ.
- WAIT: when imem_rvalid_I=1, latch inst_O=imem_rdata_I and inst_pc_O=pc_I. Drive pc_en_O=1, next_pc_O=pc_I+4, and go to HOLD. Otherwise stay in WAIT.
- HOLD: inst_valid_O = 1 & ~redirect_I & ~trap_I (combinational gate). inst_O and inst_pc_O stay stable. When inst_valid_O & inst_ready_I, go to REQ. Min fetch-to-fetch spacing: 3 cycles with zero-wait memory.
- Flush rule (trap_I or redirect_I, any state except BOOT):
  - pc_en_O=1; next_pc_O=TRAP_VEC if trap_I, else {redirect_pc_I[ADDR_W-1:2],2'b00}.
  - Trap has priority over redirect.
  - This PC load overrides any WAIT +4 update in the same cycle.
- State after a flush, by state at the time of the flush:
  - REQ with no ack: stay in REQ. The address changes next cycle, which is legal before ack.
  - REQ with ack in the same cycle: go to DRAIN.
  - WAIT with no rvalid: go to DRAIN.
  - WAIT with rvalid in the same cycle: discard the response, go to REQ.
  - HOLD: drop the instruction (no handshake occurs), go to REQ.
  - DRAIN: reload the PC, stay in DRAIN.
- DRAIN: imem_req_O=0. On imem_rvalid_I, discard the data (inst_* unchanged) and go to REQ.
- imem_rvalid_I is ignored in BOOT, REQ and HOLD, including stale responses after a mid-operation reset.
- Arithmetic: pc_I+4 wraps modulo 2^ADDR_W (0xFFFFFFFC -> 0x0).
- At most one request outstanding at any time. imem_req_O is never asserted in WAIT, HOLD or DRAIN.

Test Plan:
1. Reset: hold rst=0 for 3 cycles -> all outputs 0, state_O=0. Release -> next cycle pc_en_O=1, next_pc_O=0x0. Following cycle imem_req_O=1, imem_addr_O=0x0.
2. Sequential fetch: ack immediate, rvalid 1 cycle later returning 0x00000013/0x00100093/0x00200113, inst_ready_I=1 -> three handshakes with inst_pc_O=0x0/0x4/0x8; imem_addr_O sequence 0x0, 0x4, 0x8.
3. Backpressure: inst_ready_I=0 for 5 cycles in HOLD -> inst_valid_O=1, inst_O stable, no imem_req_O, pc_I stays 0x4. Release -> handshake, then req addr 0x4.
4. Redirect in WAIT to 0x200, response 0xDEADBEEF arrives 3 cycles later -> state DRAIN, inst_valid_O never asserted, next request addr=0x200.
5. trap_I and redirect_I (pc 0x300) together in HOLD -> inst_valid_O=0 in that cycle, next_pc_O=0x80, next request addr=0x80.
6. Boundaries:
   - Redirect to 0xFFFFFFFC, fetch completes -> pc_I=0x0.
   - Redirect to 0x103 -> request addr=0x100.
   - Redirect in REQ with ack in the same cycle -> DRAIN, that response discarded.
   - Reset asserted in WAIT, rvalid arrives during REQ -> ignored.

Source files
------------

// File: rtl/jpc_fetch_ctrl.sv
// Fetch sequencer: drives the PC register and the instruction-memory request port,
// hands fetched words to decode, and flushes on branch redirects and traps.
`ifndef JPC_ADDRESS_WIDTH
`define JPC_ADDRESS_WIDTH 32
`endif

module jpc_fetch_ctrl #(
  parameter int                ADDR_W   = `JPC_ADDRESS_WIDTH,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] TRAP_VEC = 32'h0000_0080
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_I,
  output logic [ADDR_W-1:0] next_pc_O,
  output logic              pc_en_O,
  output logic              imem_req_O,
  output logic [ADDR_W-1:0] imem_addr_O,
  input  logic              imem_ack_I,
  input  logic              imem_rvalid_I,
  input  logic [31:0]       imem_rdata_I,
  output logic              inst_valid_O,
  output logic [31:0]       inst_O,
  output logic [ADDR_W-1:0] inst_pc_O,
  input  logic              inst_ready_I,
  input  logic              redirect_I,
  input  logic [ADDR_W-1:0] redirect_pc_I,
  input  logic              trap_I,
  output logic [2:0]        state_O
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_inst;
  logic [ADDR_W-1:0] r_inst_pc;

  logic              w_flush;
  logic [ADDR_W-1:0] w_flush_pc;
  logic              w_latch;
  logic              w_pc_en;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_req;
  logic [ADDR_W-1:0] w_addr;
  logic              w_valid;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Captured instruction and its PC, held stable through HOLD
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_inst    <= 32'h0000_0000;
      r_inst_pc <= '0;
    end else if (w_latch) begin
      r_inst    <= imem_rdata_I;
      r_inst_pc <= pc_I;
    end else begin
      r_inst    <= r_inst;
      r_inst_pc <= r_inst_pc;
    end
  end

  // Next-state and per-state outputs; a flush PC load is layered on top below
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_pc_en     = 1'b0;
    w_next_pc   = '0;
    w_req       = 1'b0;
    w_addr      = '0;
    w_valid     = 1'b0;
    w_flush     = (trap_I | redirect_I) & (r_state != S_BOOT);
    w_flush_pc  = trap_I ? TRAP_VEC : {redirect_pc_I[ADDR_W-1:2], 2'b00};
    case (r_state)
      S_BOOT: begin
        w_pc_en     = 1'b1;
        w_next_pc   = RESET_PC;
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        w_req  = 1'b1;
        w_addr = pc_I;
        // An acked request under flush still returns a response that must be drained
        if (imem_ack_I) begin
          w_state_nxt = w_flush ? S_DRAIN : S_WAIT;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_I) begin
          if (w_flush) begin
            w_state_nxt = S_REQ;
          end else begin
            w_latch     = 1'b1;
            w_pc_en     = 1'b1;
            w_next_pc   = pc_I + ADDR_W'(3'd4);
            w_state_nxt = S_HOLD;
          end
        end else if (w_flush) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_HOLD: begin
        w_valid = ~redirect_I & ~trap_I;
        if (w_flush || (w_valid && inst_ready_I)) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid_I) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  assign pc_en_O      = rst & (w_pc_en | w_flush);
  assign next_pc_O    = !rst ? '0 : (w_flush ? w_flush_pc : w_next_pc);
  assign imem_req_O   = rst & w_req;
  assign imem_addr_O  = rst ? w_addr : '0;
  assign inst_valid_O = rst & w_valid;
  assign inst_O       = rst ? r_inst : 32'h0000_0000;
  assign inst_pc_O    = rst ? r_inst_pc : '0;
  assign state_O      = rst ? r_state : 3'd0;

endmodule

// File: tb/tb_jpc_fetch_ctrl.sv
// Directed walk through the fetch sequencer followed by a randomized run scored
// against a program-order PC model and an address-hashed instruction memory.
module tb_jpc_fetch_ctrl;

  localparam logic [31:0] TRAP_VEC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_r = 32'hDEAD_0000;
  logic [31:0] next_pc_O;
  logic        pc_en_O;
  logic        imem_req_O;
  logic [31:0] imem_addr_O;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid_O;
  logic [31:0] inst_O;
  logic [31:0] inst_pc_O;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        trap;
  logic [2:0]  state_O;

  int n_tests = 0;
  int n_fail  = 0;

  jpc_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .pc_I         (pc_r),
    .next_pc_O    (next_pc_O),
    .pc_en_O      (pc_en_O),
    .imem_req_O   (imem_req_O),
    .imem_addr_O  (imem_addr_O),
    .imem_ack_I   (imem_ack),
    .imem_rvalid_I(imem_rvalid),
    .imem_rdata_I (imem_rdata),
    .inst_valid_O (inst_valid_O),
    .inst_O       (inst_O),
    .inst_pc_O    (inst_pc_O),
    .inst_ready_I (inst_ready),
    .redirect_I   (redirect),
    .redirect_pc_I(redirect_pc),
    .trap_I       (trap),
    .state_O      (state_O)
  );

  always #5 clk = ~clk;

  // PC register owned by the surrounding core
  always @(posedge clk) begin
    if (pc_en_O) pc_r <= next_pc_O;
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_1357;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    imem_ack    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    trap        = 1'b0;
  endtask

  // REQ cycle with immediate ack, then WAIT cycle with the response
  task automatic start_fetch(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk); idle(); imem_ack = 1'b1; #1;
    chk("req", imem_req_O, 1);
    chk("req_addr", imem_addr_O, addr);
    chk("state_req", state_O, 3'd1);
    @(negedge clk); idle(); imem_rvalid = 1'b1; imem_rdata = data; #1;
    chk("state_wait", state_O, 3'd2);
    chk("wait_pc_en", pc_en_O, 1);
    chk("wait_next_pc", next_pc_O, addr + 32'd4);
    chk("wait_no_req", imem_req_O, 0);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
    start_fetch(addr, data);
    @(negedge clk); idle(); inst_ready = 1'b1; #1;
    chk("hold_valid", inst_valid_O, 1);
    chk("hold_inst", inst_O, data);
    chk("hold_inst_pc", inst_pc_O, addr);
    chk("state_hold", state_O, 3'd3);
  endtask

  initial begin
    logic        outstanding;
    int          cnt;
    logic [31:0] maddr;
    logic [31:0] exp_pc;
    int          nhs;

    rst = 1'b0;
    idle();
    // Reset: everything quiet, state BOOT
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_pc_en", pc_en_O, 0);
      chk("rst_next_pc", next_pc_O, 0);
      chk("rst_req", imem_req_O, 0);
      chk("rst_addr", imem_addr_O, 0);
      chk("rst_valid", inst_valid_O, 0);
      chk("rst_inst", inst_O, 0);
      chk("rst_inst_pc", inst_pc_O, 0);
      chk("rst_state", state_O, 0);
    end
    @(negedge clk); rst = 1'b1; #1;
    chk("boot_state", state_O, 0);
    chk("boot_pc_en", pc_en_O, 1);
    chk("boot_next_pc", next_pc_O, 32'h0);

    // Sequential fetch
    fetch(32'h0, 32'h0000_0013);
    fetch(32'h4, 32'h0010_0093);
    fetch(32'h8, 32'h0020_0113);

    // Backpressure in HOLD
    start_fetch(32'hC, 32'hCAFE_0001);
    repeat (5) begin
      @(negedge clk); idle(); #1;
      chk("bp_valid", inst_valid_O, 1);
      chk("bp_inst", inst_O, 32'hCAFE_0001);
      chk("bp_no_req", imem_req_O, 0);
      chk("bp_pc", pc_r, 32'h10);
    end
    @(negedge clk); idle(); inst_ready = 1'b1; #1;
    chk("bp_release_valid", inst_valid_O, 1);
    @(negedge clk); idle(); #1;
    chk("bp_next_addr", imem_addr_O, 32'h10);

    // Redirect in WAIT, late response drained
    @(negedge clk); idle(); imem_ack = 1'b1;
    @(negedge clk); idle(); redirect = 1'b1; redirect_pc = 32'h200; #1;
    chk("rdw_pc_en", pc_en_O, 1);
    chk("rdw_next_pc", next_pc_O, 32'h200);
    repeat (2) begin
      @(negedge clk); idle(); #1;
      chk("rdw_drain", state_O, 3'd4);
      chk("rdw_no_req", imem_req_O, 0);
      chk("rdw_no_valid", inst_valid_O, 0);
    end
    @(negedge clk); idle(); imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    chk("rdw_drain_rv", state_O, 3'd4);
    chk("rdw_rv_no_valid", inst_valid_O, 0);
    @(negedge clk); idle(); #1;
    chk("rdw_req_addr", imem_addr_O, 32'h200);
    chk("rdw_inst_kept", inst_O, 32'hCAFE_0001);
    fetch(32'h200, 32'h1111_2222);

    // Trap and redirect together in HOLD
    start_fetch(32'h204, 32'h3333_4444);
    @(negedge clk); idle(); trap = 1'b1; redirect = 1'b1; redirect_pc = 32'h300; inst_ready = 1'b1; #1;
    chk("trap_valid", inst_valid_O, 0);
    chk("trap_pc_en", pc_en_O, 1);
    chk("trap_next_pc", next_pc_O, TRAP_VEC);
    @(negedge clk); idle(); #1;
    chk("trap_req_addr", imem_addr_O, TRAP_VEC);

    // Redirect to top of address space, fetch wraps to 0
    @(negedge clk); idle(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    chk("wrap_next_pc", next_pc_O, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h5555_AAAA);
    @(negedge clk); idle(); #1;
    chk("wrap_pc", pc_r, 32'h0);

    // Misaligned redirect target is aligned
    @(negedge clk); idle(); redirect = 1'b1; redirect_pc = 32'h103; #1;
    chk("align_next_pc", next_pc_O, 32'h100);
    @(negedge clk); idle(); #1;
    chk("align_addr", imem_addr_O, 32'h100);

    // Redirect in REQ with ack: drain that response
    @(negedge clk); idle(); imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h400; #1;
    chk("reqack_next_pc", next_pc_O, 32'h400);
    @(negedge clk); idle(); #1;
    chk("reqack_drain", state_O, 3'd4);
    @(negedge clk); idle(); imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD; #1;
    chk("reqack_drain_rv", state_O, 3'd4);
    @(negedge clk); idle(); #1;
    chk("reqack_addr", imem_addr_O, 32'h400);
    chk("reqack_inst_kept", inst_O, 32'h5555_AAAA);

    // Reset in WAIT, stale response arrives in REQ
    @(negedge clk); idle(); imem_ack = 1'b1;
    @(negedge clk); idle(); #1;
    chk("mid_wait", state_O, 3'd2);
    rst = 1'b0; #1;
    chk("mid_rst_state", state_O, 0);
    chk("mid_rst_req", imem_req_O, 0);
    chk("mid_rst_inst", inst_O, 0);
    @(negedge clk); idle(); #1;
    chk("mid_rst_boot", state_O, 0);
    @(negedge clk); rst = 1'b1; #1;
    chk("mid_boot_pc_en", pc_en_O, 1);
    @(negedge clk); idle(); imem_rvalid = 1'b1; imem_rdata = 32'h7777_7777; #1;
    chk("stale_req", imem_req_O, 1);
    chk("stale_addr", imem_addr_O, 32'h0);
    @(negedge clk); idle(); #1;
    chk("stale_state", state_O, 3'd1);
    chk("stale_inst", inst_O, 32'h0);
    chk("stale_valid", inst_valid_O, 0);

    // Randomized run against program-order model
    outstanding = 1'b0;
    cnt         = 0;
    maddr       = 32'h0;
    exp_pc      = 32'h0;
    nhs         = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); idle();
      inst_ready  = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      trap        = ($urandom_range(0, 49) == 0);
      if (outstanding) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem(maddr);
        end
      end
      #1;
      if (outstanding) chk("rnd_one_outstanding", imem_req_O, 0);
      if (imem_req_O && !outstanding && ($urandom_range(0, 1) == 1)) begin
        imem_ack = 1'b1;
        maddr    = imem_addr_O;
      end
      #1;
      if (redirect || trap) chk("rnd_flush_valid", inst_valid_O, 0);
      if (inst_valid_O && inst_ready) begin
        chk("rnd_inst_pc", inst_pc_O, exp_pc);
        chk("rnd_inst", inst_O, mem(exp_pc));
        exp_pc = exp_pc + 32'd4;
        nhs++;
      end
      if (trap) exp_pc = TRAP_VEC;
      else if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
      if (imem_rvalid) outstanding = 1'b0;
      if (imem_ack) begin
        outstanding = 1'b1;
        cnt         = $urandom_range(1, 3);
      end
    end
    chk("rnd_progress", (nhs > 50) ? 32'd1 : 32'd0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
